// File: rtl/dbg_trace_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dbg_trace_pkg
//  Description : Shared types for the debug trace capture engine: capture
//                state encoding and a status bundle for debug-register views.
//  Revision    : 1.0  initial release
// ============================================================================
package dbg_trace_pkg;

    // Widest buffer address the status bundle can carry; instances with a
    // narrower AW zero-extend their pointers into it.
    localparam int unsigned C_TRACE_AW_MAX = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_POST = 2'd2,
        ST_DONE = 2'd3
    } trace_state_e;

    typedef struct packed {
        logic                      busy;
        logic                      triggered;
        logic                      done;
        logic                      wrapped;
        logic [C_TRACE_AW_MAX-1:0] wr_ptr;
        logic [C_TRACE_AW_MAX-1:0] trig_addr;
    } trace_status_t;

endpackage : dbg_trace_pkg
`default_nettype wire

// File: rtl/dbg_trace_ram.sv
`default_nettype none
// ============================================================================
//  Module      : dbg_trace_ram
//  Description : Simple dual-port trace buffer, one write port and one
//                registered read port on the same clock, read-first.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_we/i_waddr/i_wdata - write port
//                i_re/i_raddr    - read request and address
//                o_rdata/o_rvalid - read data and valid, one cycle after i_re
//  Revision    : 1.0  initial release
// ============================================================================
module dbg_trace_ram #(
    parameter int DATA_W = 1230,
    parameter int DEPTH  = 512
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [DATA_W-1:0]        o_rdata,
    output logic                     o_rvalid
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid;

    // Array kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Non-blocking read of the array gives the pre-write value on a
    // same-address collision (read-first).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= i_re;
            if (i_re) begin
                r_rdata <= r_mem[i_raddr];
            end
        end
    end

    assign o_rdata  = r_rdata;
    assign o_rvalid = r_rvalid;

endmodule : dbg_trace_ram
`default_nettype wire

// File: rtl/dbg_trace_capture.sv
`default_nettype none
// ============================================================================
//  Module      : dbg_trace_capture
//  Description : Multi-channel trace recorder. Selects one sample stream on
//                arm, records it into a circular buffer, fires on a masked
//                match and keeps a programmable number of post-trigger
//                samples so pre-trigger history is preserved.
//  Ports       : clk, rst               - clock, synchronous active-high reset
//                ch_data_i/ch_valid_i   - NCH sample streams
//                cfg_*                  - capture configuration (static while busy)
//                arm_i/abort_i          - control pulses
//                busy_o..trig_addr_o    - capture status
//                rd_en_i/rd_addr_i      - buffer read request
//                rd_data_o/rd_valid_o   - read data, one cycle after request
//  Revision    : 1.0  initial release
// ============================================================================
module dbg_trace_capture
    import dbg_trace_pkg::*;
#(
    parameter int DATA_W = 1230,
    parameter int DEPTH  = 512,
    parameter int NCH    = 2,
    parameter int AW     = $clog2(DEPTH),
    parameter int SW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH*DATA_W-1:0] ch_data_i,
    input  logic [NCH-1:0]        ch_valid_i,
    input  logic [SW-1:0]         cfg_sel_i,
    input  logic                  cfg_wrap_i,
    input  logic [DATA_W-1:0]     cfg_match_i,
    input  logic [DATA_W-1:0]     cfg_mask_i,
    input  logic [AW-1:0]         cfg_post_i,
    input  logic                  arm_i,
    input  logic                  abort_i,
    output logic                  busy_o,
    output logic                  triggered_o,
    output logic                  done_o,
    output logic                  wrapped_o,
    output logic [AW-1:0]         wr_ptr_o,
    output logic [AW-1:0]         trig_addr_o,
    input  logic                  rd_en_i,
    input  logic [AW-1:0]         rd_addr_i,
    output logic [DATA_W-1:0]     rd_data_o,
    output logic                  rd_valid_o
);

    trace_state_e      r_state;
    trace_state_e      w_state_nxt;

    logic [SW-1:0]     r_sel;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_trig_addr;
    logic [AW-1:0]     r_post_cnt;
    logic              r_triggered;
    logic              r_wrapped;

    logic [DATA_W-1:0] w_smp_data;
    logic              w_smp_valid;
    logic              w_match;
    logic              w_busy;
    logic              w_arm;
    logic              w_we;
    logic              w_trig;
    logic              w_final;

    // ------------------------------------------------------------------
    // Channel mux on the select latched at arm
    // ------------------------------------------------------------------
    always_comb begin
        w_smp_data  = '0;
        w_smp_valid = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (r_sel == SW'(c)) begin
                w_smp_data  = ch_data_i[c*DATA_W +: DATA_W];
                w_smp_valid = ch_valid_i[c];
            end
        end
    end

    assign w_match = (((w_smp_data ^ cfg_match_i) & cfg_mask_i) == '0);
    assign w_busy  = (r_state == ST_PRE) || (r_state == ST_POST);
    // Abort beats arm; arm is only honoured outside a running capture.
    assign w_arm   = arm_i && !abort_i && !w_busy;
    // An aborting cycle records nothing.
    assign w_we    = w_busy && w_smp_valid && !abort_i;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_trig      = 1'b0;
        w_final     = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_arm) begin
                    w_state_nxt = ST_PRE;
                end
            end
            ST_PRE: begin
                // One-shot mode fires on the first recorded sample.
                if (w_we && (!cfg_wrap_i || w_match)) begin
                    w_trig = 1'b1;
                    if (r_post_cnt == '0) begin
                        w_final     = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_POST;
                    end
                end
            end
            ST_POST: begin
                if (w_we && (r_post_cnt == AW'(1))) begin
                    w_final     = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (abort_i) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Pointers, counters and flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel       <= '0;
            r_wr_ptr    <= '0;
            r_trig_addr <= '0;
            r_post_cnt  <= '0;
            r_triggered <= 1'b0;
            r_wrapped   <= 1'b0;
        end else if (w_arm) begin
            r_sel       <= cfg_sel_i;
            r_wr_ptr    <= '0;
            r_triggered <= 1'b0;
            r_wrapped   <= 1'b0;
            // One-shot keeps DEPTH-1 samples after the forced trigger,
            // filling the buffer exactly once.
            r_post_cnt  <= cfg_wrap_i ? cfg_post_i : '1;
        end else if (w_we) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
            // The completing write never flags a wrap, so a capture that
            // exactly fills the buffer reads back as a linear record.
            if ((&r_wr_ptr) && !w_final) begin
                r_wrapped <= 1'b1;
            end
            if (w_trig) begin
                r_triggered <= 1'b1;
                r_trig_addr <= r_wr_ptr;
            end
            if (r_state == ST_POST) begin
                r_post_cnt <= r_post_cnt - AW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Trace buffer
    // ------------------------------------------------------------------
    dbg_trace_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_we),
        .i_waddr  (r_wr_ptr),
        .i_wdata  (w_smp_data),
        .i_re     (rd_en_i),
        .i_raddr  (rd_addr_i),
        .o_rdata  (rd_data_o),
        .o_rvalid (rd_valid_o)
    );

    assign busy_o      = w_busy;
    assign done_o      = (r_state == ST_DONE);
    assign triggered_o = r_triggered;
    assign wrapped_o   = r_wrapped;
    assign wr_ptr_o    = r_wr_ptr;
    assign trig_addr_o = r_trig_addr;

endmodule : dbg_trace_capture
`default_nettype wire

// File: tb/tb_dbg_trace_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dbg_trace_capture
//  Description : Self-checking bench for dbg_trace_capture (DATA_W=8,
//                DEPTH=16, NCH=2): scenario table, directed corner-case
//                sequences and randomized traffic against a reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dbg_trace_capture;

    localparam int DW  = 8;
    localparam int DEP = 16;
    localparam int NC  = 2;
    localparam int AWL = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NC*DW-1:0]  ch_data_i;
    logic [NC-1:0]     ch_valid_i;
    logic [0:0]        cfg_sel_i;
    logic              cfg_wrap_i;
    logic [DW-1:0]     cfg_match_i;
    logic [DW-1:0]     cfg_mask_i;
    logic [AWL-1:0]    cfg_post_i;
    logic              arm_i;
    logic              abort_i;
    logic              busy_o;
    logic              triggered_o;
    logic              done_o;
    logic              wrapped_o;
    logic [AWL-1:0]    wr_ptr_o;
    logic [AWL-1:0]    trig_addr_o;
    logic              rd_en_i;
    logic [AWL-1:0]    rd_addr_i;
    logic [DW-1:0]     rd_data_o;
    logic              rd_valid_o;

    always #5 clk = ~clk;

    dbg_trace_capture #(
        .DATA_W (DW),
        .DEPTH  (DEP),
        .NCH    (NC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ch_data_i   (ch_data_i),
        .ch_valid_i  (ch_valid_i),
        .cfg_sel_i   (cfg_sel_i),
        .cfg_wrap_i  (cfg_wrap_i),
        .cfg_match_i (cfg_match_i),
        .cfg_mask_i  (cfg_mask_i),
        .cfg_post_i  (cfg_post_i),
        .arm_i       (arm_i),
        .abort_i     (abort_i),
        .busy_o      (busy_o),
        .triggered_o (triggered_o),
        .done_o      (done_o),
        .wrapped_o   (wrapped_o),
        .wr_ptr_o    (wr_ptr_o),
        .trig_addr_o (trig_addr_o),
        .rd_en_i     (rd_en_i),
        .rd_addr_i   (rd_addr_i),
        .rd_data_o   (rd_data_o),
        .rd_valid_o  (rd_valid_o)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: counts samples since arm and samples since trigger
    // ------------------------------------------------------------------
    bit         m_busy, m_done, m_trig, m_wrapped, m_rd_valid;
    bit         m_rd_known = 1'b1;
    int         m_ptr, m_trig_addr, m_nwr, m_nafter, m_target, m_sel;
    logic [7:0] m_rd_data;
    logic [7:0] m_mem [DEP];
    bit         m_known [DEP];

    task automatic model_edge();
        logic [7:0] d;
        bit         fin;
        if (rst) begin
            m_busy = 0; m_done = 0; m_trig = 0; m_wrapped = 0;
            m_ptr = 0; m_trig_addr = 0; m_nwr = 0;
            m_rd_valid = 0; m_rd_data = '0; m_rd_known = 1;
            for (int i = 0; i < DEP; i++) m_known[i] = 0;
            return;
        end
        m_rd_valid = rd_en_i;
        if (rd_en_i) begin
            m_rd_known = m_known[rd_addr_i];
            m_rd_data  = m_mem[rd_addr_i];
        end
        if (abort_i) begin
            m_busy = 0;
            m_done = 0;
            return;
        end
        if (arm_i && !m_busy) begin
            m_busy = 1; m_done = 0; m_trig = 0; m_wrapped = 0;
            m_ptr = 0; m_nwr = 0; m_nafter = 0;
            m_target = cfg_wrap_i ? int'(cfg_post_i) : DEP - 1;
            m_sel = int'(cfg_sel_i);
            return;
        end
        if (m_busy && ch_valid_i[m_sel]) begin
            d = ch_data_i[m_sel*DW +: DW];
            m_mem[m_ptr]   = d;
            m_known[m_ptr] = 1;
            fin = 0;
            if (!m_trig) begin
                if (!cfg_wrap_i || (((d ^ cfg_match_i) & cfg_mask_i) == 8'h00)) begin
                    m_trig = 1;
                    m_trig_addr = m_ptr;
                    m_nafter = 0;
                    fin = (m_target == 0);
                end
            end else begin
                m_nafter++;
                fin = (m_nafter == m_target);
            end
            m_nwr++;
            m_ptr = m_nwr % DEP;
            if ((m_nwr % DEP == 0) && !fin) m_wrapped = 1;
            if (fin) begin
                m_busy = 0;
                m_done = 1;
            end
        end
    endtask

    // One clock: update the model from the inputs about to be sampled,
    // then compare every output 1 time unit after the edge.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check("busy",      busy_o,      m_busy);
        check("done",      done_o,      m_done);
        check("triggered", triggered_o, m_trig);
        check("wrapped",   wrapped_o,   m_wrapped);
        check("wr_ptr",    wr_ptr_o,    m_ptr);
        check("trig_addr", trig_addr_o, m_trig_addr);
        check("rd_valid",  rd_valid_o,  m_rd_valid);
        if (m_rd_known) check("rd_data", rd_data_o, m_rd_data);
    endtask

    task automatic quiet();
        rst = 0; arm_i = 0; abort_i = 0; rd_en_i = 0; rd_addr_i = '0;
        ch_valid_i = '0; ch_data_i = '0;
    endtask

    // ------------------------------------------------------------------
    // Scenario table
    // ------------------------------------------------------------------
    typedef struct {
        bit         wrap;
        bit         sel;
        logic [7:0] mask;
        logic [7:0] match;
        logic [3:0] post;
        int         period;
        int         exp_trig;
        int         exp_ptr;
        bit         exp_wrapped;
        int         exp_first;   // value of the oldest entry (at exp_ptr)
    } scen_t;

    task automatic run_scen(input scen_t s, input int idx);
        int v;
        int cyc;
        cfg_wrap_i  = s.wrap;
        cfg_sel_i   = s.sel;
        cfg_mask_i  = s.mask;
        cfg_match_i = s.match;
        cfg_post_i  = s.post;
        ch_valid_i  = '0;
        arm_i = 1; tick(); arm_i = 0;
        v = 0; cyc = 0;
        while (!done_o && cyc < 200) begin
            ch_data_i  = NC*DW'($urandom);
            ch_valid_i = NC'($urandom);
            ch_valid_i[s.sel] = (cyc % s.period == 0);
            if (cyc % s.period == 0) begin
                ch_data_i[s.sel*DW +: DW] = 8'(v);
                v++;
            end
            tick();
            cyc++;
        end
        ch_valid_i = '0;
        check($sformatf("scen%0d_done", idx),      done_o,      1);
        check($sformatf("scen%0d_trig", idx),      triggered_o, 1);
        check($sformatf("scen%0d_trig_addr", idx), trig_addr_o, s.exp_trig);
        check($sformatf("scen%0d_wr_ptr", idx),    wr_ptr_o,    s.exp_ptr);
        check($sformatf("scen%0d_wrapped", idx),   wrapped_o,   s.exp_wrapped);
        for (int k = 0; k < DEP; k++) begin
            rd_en_i   = 1;
            rd_addr_i = AWL'((s.exp_ptr + k) % DEP);
            tick();
            check($sformatf("scen%0d_ram[%0d]", idx, rd_addr_i), rd_data_o, s.exp_first + k);
        end
        rd_en_i = 0;
    endtask

    scen_t tbl [5];

    initial begin
        // wrap sel mask   match  post   per trig ptr wrapped first
        tbl[0] = '{1'b0, 1'b0, 8'h00, 8'h00, 4'd0,  1, 0, 0, 1'b0, 0};   // one-shot
        tbl[1] = '{1'b1, 1'b1, 8'hFF, 8'h14, 4'd3,  1, 4, 8, 1'b1, 8};   // circular trigger
        tbl[2] = '{1'b0, 1'b0, 8'h00, 8'h00, 4'd0,  3, 0, 0, 1'b0, 0};   // gapped valid
        tbl[3] = '{1'b1, 1'b0, 8'h00, 8'h00, 4'd15, 1, 0, 0, 1'b0, 0};   // trigger kept as oldest
        tbl[4] = '{1'b1, 1'b1, 8'hF0, 8'h30, 4'd2,  2, 0, 3, 1'b1, 35};  // partial mask

        quiet();
        cfg_sel_i = '0; cfg_wrap_i = 0; cfg_match_i = '0; cfg_mask_i = '0; cfg_post_i = '0;

        // Reset state
        rst = 1; tick(); tick(); rst = 0;
        check("reset_busy",   busy_o,     0);
        check("reset_rdata",  rd_data_o,  0);
        check("reset_rvalid", rd_valid_o, 0);

        for (int i = 0; i < 5; i++) run_scen(tbl[i], i);

        // Read latency, hold, and read/write collision (RAM from scenario 4)
        rd_en_i = 1; rd_addr_i = 4'd5; tick();
        check("rd5_valid", rd_valid_o, 1);
        check("rd5_data",  rd_data_o,  8'h25);
        rd_en_i = 0; tick();
        check("rd_idle_valid", rd_valid_o, 0);
        check("rd_hold_data",  rd_data_o,  8'h25);
        cfg_wrap_i = 0; cfg_sel_i = 0;
        arm_i = 1; tick(); arm_i = 0;
        ch_valid_i = 2'b01; ch_data_i = 16'h0077; rd_en_i = 1; rd_addr_i = 4'd0; tick();
        check("collide_old_data", rd_data_o, 8'h30);
        check("collide_wr_ptr",   wr_ptr_o,  1);
        ch_valid_i = '0; tick();
        check("after_write_data", rd_data_o, 8'h77);
        rd_en_i = 0; abort_i = 1; tick(); abort_i = 0;
        check("abort_pre_busy", busy_o, 0);

        // Abort in POST with two samples remaining
        cfg_wrap_i = 1; cfg_sel_i = 0; cfg_mask_i = 8'hFF; cfg_match_i = 8'h05; cfg_post_i = 4'd4;
        arm_i = 1; tick(); arm_i = 0;
        for (int v = 0; v < 8; v++) begin
            ch_valid_i = 2'b01; ch_data_i = {8'h00, 8'(v)}; tick();
        end
        check("post_busy", busy_o, 1);
        abort_i = 1; ch_data_i = 16'h0008; tick(); abort_i = 0; ch_valid_i = '0;
        check("abort_busy",      busy_o,      0);
        check("abort_done",      done_o,      0);
        check("abort_triggered", triggered_o, 1);
        check("abort_wr_ptr",    wr_ptr_o,    8);
        check("abort_trig_addr", trig_addr_o, 5);
        rd_en_i = 1; rd_addr_i = 4'd8; tick(); rd_en_i = 0;
        check("abort_no_write", rd_data_o, 8'h28);
        arm_i = 1; abort_i = 1; tick(); arm_i = 0; abort_i = 0;
        check("arm_abort_busy", busy_o, 0);

        // Reset mid-PRE, then a fresh capture starts at address 0
        cfg_mask_i = 8'hFF; cfg_match_i = 8'hFF; cfg_post_i = 4'd0;
        arm_i = 1; tick(); arm_i = 0;
        for (int v = 1; v <= 3; v++) begin
            ch_valid_i = 2'b01; ch_data_i = {8'h00, 8'(v)}; rd_en_i = 1; rd_addr_i = 4'd8; tick();
        end
        check("prerst_busy", busy_o, 1);
        rst = 1; ch_valid_i = '0; rd_en_i = 0; tick(); rst = 0;
        check("rst_busy",      busy_o,      0);
        check("rst_triggered", triggered_o, 0);
        check("rst_done",      done_o,      0);
        check("rst_wrapped",   wrapped_o,   0);
        check("rst_wr_ptr",    wr_ptr_o,    0);
        check("rst_trig_addr", trig_addr_o, 0);
        check("rst_rd_data",   rd_data_o,   0);
        check("rst_rd_valid",  rd_valid_o,  0);
        cfg_wrap_i = 0;
        arm_i = 1; tick(); arm_i = 0;
        ch_valid_i = 2'b01; ch_data_i = 16'h00A0; tick(); ch_valid_i = '0;
        check("rearm_wr_ptr", wr_ptr_o, 1);
        rd_en_i = 1; rd_addr_i = 4'd0; tick(); rd_en_i = 0;
        check("rearm_addr0", rd_data_o, 8'hA0);
        abort_i = 1; tick(); abort_i = 0;

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 599) == 0);
            if (!m_busy) begin
                cfg_wrap_i  = ($urandom_range(0, 3) != 0);
                cfg_sel_i   = 1'($urandom);
                cfg_mask_i  = 8'($urandom) & 8'h1F;
                cfg_match_i = 8'($urandom) & 8'h1F;
                cfg_post_i  = 4'($urandom);
            end
            arm_i      = ($urandom_range(0, 15) == 0);
            abort_i    = ($urandom_range(0, 79) == 0);
            ch_valid_i = 2'($urandom);
            ch_data_i  = {3'b000, 5'($urandom), 3'b000, 5'($urandom)};
            rd_en_i    = 1'($urandom);
            rd_addr_i  = 4'($urandom);
            tick();
        end
        quiet();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_dbg_trace_capture
`default_nettype wire
